// File: rtl/uart_pkg.sv
// Shared constants, helpers and state encodings for the FIFO-to-UART
// return path (unpacker top level and the uart_tx serialiser).
package uart_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CLK_FREQ   = 100_000_000;
    localparam int DEF_BAUD_RATE  = 115200;
    localparam int DEF_WORD_WIDTH = 128;

    // Integer division: 868 clocks per bit at the defaults.
    function automatic int calc_clks_per_bit(
        input int clk_freq,
        input int baud_rate
    );
        return clk_freq / baud_rate;
    endfunction

    function automatic int calc_bytes_per_word(
        input int word_width,
        input int data_width
    );
        return word_width / data_width;
    endfunction

    localparam int DEF_CLKS_PER_BIT =
        calc_clks_per_bit(DEF_CLK_FREQ, DEF_BAUD_RATE);
    localparam int DEF_BYTES_PER_WORD =
        calc_bytes_per_word(DEF_WORD_WIDTH, DEF_DATA_WIDTH);

    typedef enum logic [1:0] {
        UNP_IDLE,
        UNP_FETCH,
        UNP_ISSUE,
        UNP_WAIT_TX
    } unp_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/fifo_to_uart_tx_uart_tx.sv
// uart_tx: standalone 8N1 serialiser, one start, TB_DATA_WIDTH data bits
// LSB first, one stop bit, each held for CLKS_PER_BIT clocks.
// Ports: clk, rst (async, active-low), tx_start/tx_data (accepted when
// idle), tx (line, idles high), tx_busy, tx_done (last cycle of stop bit).
module uart_tx
    import uart_pkg::*;
#(
    parameter int TB_DATA_WIDTH = 8,
    parameter int CLKS_PER_BIT  = 868
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tx_start,
    input  logic [TB_DATA_WIDTH-1:0] tx_data,
    output logic                     tx,
    output logic                     tx_busy,
    output logic                     tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (TB_DATA_WIDTH > 1) ? $clog2(TB_DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(TB_DATA_WIDTH - 1);

    tx_state_e                state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [BW-1:0]            bit_q, bit_d;
    logic [TB_DATA_WIDTH-1:0] shift_q, shift_d;
    logic                     tx_q, tx_d;
    logic                     bit_end;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        bit_end = (cnt_q == CNT_LAST);
        // Baud counter restarts at every bit boundary.
        if (state_q != TX_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end
        unique case (state_q)
            TX_IDLE: begin
                if (tx_start) begin
                    state_d = TX_START;
                    shift_d = tx_data;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != TX_IDLE);
    assign tx_done = (state_q == TX_STOP) && bit_end;

endmodule

// File: rtl/fifo_to_uart_tx.sv
// fifo_to_uart_tx: pops WORD_WIDTH-bit words from a sync FIFO and sends
// them byte 0 (LSBs) first as 8N1 frames on tx.
// Ports: clk, rst (async, active-low), en (gates new fetches),
// fifo_empty/fifo_rd_en/fifo_rd_data (FIFO read side, data one cycle
// after pop), tx, busy, byte_done and word_done pulses.
module fifo_to_uart_tx
    import uart_pkg::*;
#(
    parameter int TB_DATA_WIDTH = 8,
    parameter int TB_CLK_FREQ   = 100_000_000,
    parameter int TB_BAUD_RATE  = 115200,
    parameter int WORD_WIDTH    = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [WORD_WIDTH-1:0] fifo_rd_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  byte_done,
    output logic                  word_done
);

    localparam int CLKS_PER_BIT =
        calc_clks_per_bit(TB_CLK_FREQ, TB_BAUD_RATE);
    localparam int BYTES_PER_WORD =
        calc_bytes_per_word(WORD_WIDTH, TB_DATA_WIDTH);
    localparam int IW =
        (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(BYTES_PER_WORD - 1);

    unp_state_e            state_q, state_d;
    logic [WORD_WIDTH-1:0] word_reg_q, word_reg_d;
    logic [IW-1:0]         byte_idx_q, byte_idx_d;
    logic                  tx_start;
    logic                  tx_busy;
    logic                  tx_done;

    always_comb begin
        state_d    = state_q;
        word_reg_d = word_reg_q;
        byte_idx_d = byte_idx_q;
        fifo_rd_en = 1'b0;
        tx_start   = 1'b0;
        byte_done  = 1'b0;
        word_done  = 1'b0;
        unique case (state_q)
            UNP_IDLE: begin
                fifo_rd_en = en & ~fifo_empty;
                if (fifo_rd_en) begin
                    state_d = UNP_FETCH;
                end
            end
            UNP_FETCH: begin
                word_reg_d = fifo_rd_data;
                byte_idx_d = '0;
                state_d    = UNP_ISSUE;
            end
            UNP_ISSUE: begin
                tx_start = 1'b1;
                state_d  = UNP_WAIT_TX;
            end
            UNP_WAIT_TX: begin
                if (tx_done) begin
                    byte_done = 1'b1;
                    if (byte_idx_q == IDX_LAST) begin
                        word_done = 1'b1;
                        state_d   = UNP_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        // Shift so byte byte_idx is always at the bottom.
                        word_reg_d = word_reg_q >> TB_DATA_WIDTH;
                        state_d    = UNP_ISSUE;
                    end
                end
            end
            default: state_d = UNP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= UNP_IDLE;
            word_reg_q <= '0;
            byte_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            word_reg_q <= word_reg_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    assign busy = (state_q != UNP_IDLE) | tx_busy;

    uart_tx #(
        .TB_DATA_WIDTH(TB_DATA_WIDTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk     (clk),
        .rst     (rst),
        .tx_start(tx_start),
        .tx_data (word_reg_q[TB_DATA_WIDTH-1:0]),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

endmodule
